// File: rtl/flash_image_loader.sv
// flash_image_loader: streams one table-selected image from flash into the frame buffer,
// one flash read per busy handshake, with abort, selection error and re-trigger support.
module flash_image_loader #(
  parameter int NUM_IMG = 8,
  parameter int SEL_W = 3,
  parameter int ADDR_W = 23,
  parameter int CNT_W = 19,
  parameter int DATA_W = 16,
  parameter logic [NUM_IMG*ADDR_W-1:0] IMG_BASE = {
    ADDR_W'(0), ADDR_W'(0), ADDR_W'(0), ADDR_W'(921601),
    ADDR_W'(1), ADDR_W'(1152001), ADDR_W'(614401), ADDR_W'(307201)},
  parameter logic [NUM_IMG*CNT_W-1:0] IMG_LEN = {
    CNT_W'(0), CNT_W'(0), CNT_W'(0), CNT_W'(260400),
    CNT_W'(307200), CNT_W'(307200), CNT_W'(307200), CNT_W'(307200)}
) (
  input  logic              clk,
  input  logic              flashreset,
  input  logic              start,
  input  logic [SEL_W-1:0]  pictsel,
  input  logic              abort,
  input  logic              busy,
  input  logic [DATA_W-1:0] fdata,
  output logic              writemode,
  output logic              doread,
  output logic [ADDR_W-1:0] flashaddr,
  output logic              pix_we,
  output logic [CNT_W-1:0]  pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              active,
  output logic              loaded,
  output logic              sel_err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_HI, WAIT_LO, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] remaining, len_sel;
  logic [ADDR_W-1:0] base_sel;
  logic hold, accept, stop, last, loading;
  // Entries past NUM_IMG fall through with length 0 and so read as invalid
  always_comb begin
    base_sel = '0;
    len_sel = '0;
    for (int i = 0; i < NUM_IMG; i++)
      if (pictsel == SEL_W'(i)) begin
        base_sel = IMG_BASE[i*ADDR_W +: ADDR_W];
        len_sel = IMG_LEN[i*CNT_W +: CNT_W];
      end
  end
  assign loading = state == REQ || state == WAIT_HI || state == WAIT_LO || state == WRITE;
  assign accept = (state == IDLE || state == DONE) && start && !(hold && busy);
  assign stop = loading && abort;
  assign last = remaining == CNT_W'(1);
  always_ff @(posedge clk or posedge flashreset)
    if (flashreset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (stop) state_n = DONE;
    else
      case (state)
        IDLE, DONE: state_n = accept ? (len_sel != '0 ? REQ : DONE) : state;
        REQ:        state_n = busy ? WAIT_HI : REQ;
        WAIT_HI:    state_n = busy ? WAIT_HI : WAIT_LO;
        WAIT_LO:    state_n = WRITE;
        WRITE:      state_n = last ? DONE : REQ;
        default:    state_n = IDLE;
      endcase
  end
  always_comb begin
    doread = state == REQ;
    pix_we = state == WRITE;
  end
  // An abort while the flash manager is mid-read blocks restarts until it goes idle
  always_ff @(posedge clk or posedge flashreset)
    if (flashreset) begin
      writemode <= 1'b1;
      flashaddr <= '0;
      pix_addr <= '0;
      pix_data <= '0;
      remaining <= '0;
      active <= 1'b0;
      loaded <= 1'b0;
      sel_err <= 1'b0;
      hold <= 1'b0;
    end else begin
      if (stop && state == WAIT_HI && busy) hold <= 1'b1;
      else if (!busy) hold <= 1'b0;
      if (accept) begin
        loaded <= 1'b0;
        sel_err <= len_sel == '0;
        if (len_sel != '0) begin
          flashaddr <= base_sel;
          remaining <= len_sel;
          pix_addr <= '0;
          writemode <= 1'b0;
          active <= 1'b1;
        end
      end else if (stop) begin
        active <= 1'b0;
        loaded <= 1'b0;
      end else if (state == WAIT_LO) pix_data <= fdata;
      else if (state == WRITE) begin
        remaining <= remaining - CNT_W'(1);
        if (last) begin
          loaded <= 1'b1;
          active <= 1'b0;
        end else begin
          flashaddr <= flashaddr + ADDR_W'(1);
          pix_addr <= pix_addr + CNT_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_flash_image_loader.sv
// tb_flash_image_loader: randomized and directed checks of flash_image_loader against
// an image-table model and a simple busy-handshake flash responder.
module tb_flash_image_loader;
  localparam logic [8*23-1:0] BASE = {23'd70000, 23'd9, 23'd0, 23'd40000,
                                      23'd500, 23'd2000, 23'd100, 23'd7};
  localparam logic [8*19-1:0] LEN = {19'd2, 19'd0, 19'd0, 19'd3,
                                     19'd3, 19'd5, 19'd4, 19'd2};
  int ref_base[8] = '{7, 100, 2000, 500, 40000, 0, 9, 70000};
  int ref_len[8] = '{2, 4, 5, 3, 3, 0, 0, 2};
  logic clk = 1'b0;
  logic flashreset, start, abort, busy;
  logic [2:0] pictsel;
  logic [15:0] fdata, fl_addr;
  logic writemode, doread, pix_we, active, loaded, sel_err;
  logic [22:0] flashaddr;
  logic [18:0] pix_addr;
  logic [15:0] pix_data;
  int checks = 0, errors = 0, busy_len = 3, rd_cnt = 0;
  typedef struct {int a; int d;} wr_t;
  wr_t wr_q[$];
  flash_image_loader #(.IMG_BASE(BASE), .IMG_LEN(LEN)) dut (
    .clk(clk), .flashreset(flashreset), .start(start), .pictsel(pictsel),
    .abort(abort), .busy(busy), .fdata(fdata), .writemode(writemode),
    .doread(doread), .flashaddr(flashaddr), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_data(pix_data), .active(active), .loaded(loaded), .sel_err(sel_err));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (pix_we === 1'b1) wr_q.push_back('{a: int'(pix_addr), d: int'(pix_data)});
    if (doread === 1'b1) rd_cnt++;
  end
  // Flash responder: busy for busy_len cycles per read, data = address ^ A5A5
  initial begin
    busy = 1'b0;
    fdata = '0;
    forever begin
      @(negedge clk);
      if (doread === 1'b1 && !busy) begin
        fl_addr = flashaddr[15:0];
        busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
        fdata = fl_addr ^ 16'hA5A5;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
  task automatic pulse_start(input int sel);
    @(negedge clk);
    pictsel = 3'(sel);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!active) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic wait_wait_hi(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && !doread && active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset;
    flashreset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pictsel = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({writemode, doread, pix_we, active, loaded, sel_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b want 100000", {writemode, doread, pix_we, active, loaded, sel_err});
    end
    checks++;
    if (flashaddr !== '0 || pix_addr !== '0 || pix_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %0d/%0d/%0d want 0/0/0", flashaddr, pix_addr, pix_data);
    end
    flashreset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    bit ok;
    busy_len = 3;
    wr_q.delete();
    pulse_start(1);
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() != 4) begin
      errors++;
      $display("FAIL basic_count got %0d want 4 (ok=%0d)", wr_q.size(), ok);
    end
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      checks++;
      if (wr_q[i].a != i || wr_q[i].d != int'(16'(100 + i) ^ 16'hA5A5)) begin
        errors++;
        $display("FAIL basic_write%0d got %0d:%h want %0d:%h", i, wr_q[i].a, wr_q[i].d, i, 16'(100 + i) ^ 16'hA5A5);
      end
    end
    checks++;
    if ({loaded, active, writemode} !== 3'b100 || flashaddr !== 23'd103) begin
      errors++;
      $display("FAIL basic_end got loaded=%b active=%b wm=%b fa=%0d want 1 0 0 103", loaded, active, writemode, flashaddr);
    end
  endtask
  task automatic test_sel_err;
    bit ok;
    wr_q.delete();
    rd_cnt = 0;
    pulse_start(6);
    checks++;
    if ({sel_err, loaded, active} !== 3'b100) begin
      errors++;
      $display("FAIL selerr_flags got %b want 100", {sel_err, loaded, active});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL selerr_quiet got reads=%0d writes=%0d want 0 0", rd_cnt, wr_q.size());
    end
    pulse_start(0);
    checks++;
    if ({sel_err, active} !== 2'b01) begin
      errors++;
      $display("FAIL selerr_clear got %b want 01", {sel_err, active});
    end
    wait_idle(ok);
    checks++;
    if (!ok || loaded !== 1'b1 || wr_q.size() != 2) begin
      errors++;
      $display("FAIL selerr_reload got loaded=%b writes=%0d want 1 2", loaded, wr_q.size());
    end
  endtask
  task automatic test_abort;
    bit ok;
    int n = 0;
    wr_q.delete();
    pulse_start(1);
    for (int i = 0; i < 500; i++) begin
      if (pix_we) n++;
      if (n == 2) break;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({active, loaded} !== 2'b00) begin
      errors++;
      $display("FAIL abort_flags got %b want 00", {active, loaded});
    end
    repeat (30) @(negedge clk);
    checks++;
    if (wr_q.size() != 2 || loaded !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got writes=%0d loaded=%b active=%b want 2 0 0", wr_q.size(), loaded, active);
    end
    wr_q.delete();
    pulse_start(1);
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() != 4 || wr_q[0].a != 0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got writes=%0d loaded=%b want 4 1", wr_q.size(), loaded);
    end
  endtask
  task automatic test_ignore_start;
    int bad = 0;
    wr_q.delete();
    pulse_start(1);
    for (int i = 0; i < 500 && active; i++) begin
      if (flashaddr < 23'd100 || flashaddr > 23'd103) bad++;
      if (i == 6) begin
        pictsel = 3'd3;
        start = 1'b1;
      end
      if (i == 7) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || wr_q.size() != 4 || flashaddr !== 23'd103 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start got bad=%0d writes=%0d fa=%0d loaded=%b want 0 4 103 1", bad, wr_q.size(), flashaddr, loaded);
    end
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      checks++;
      if (wr_q[i].d != int'(16'(100 + i) ^ 16'hA5A5)) begin
        errors++;
        $display("FAIL ignore_data%0d got %h want %h", i, wr_q[i].d, 16'(100 + i) ^ 16'hA5A5);
      end
    end
  endtask
  task automatic test_back_to_back;
    bit ok;
    wr_q.delete();
    pulse_start(0);
    checks++;
    if ({loaded, active} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept got %b want 01", {loaded, active});
    end
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() != 2 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got writes=%0d loaded=%b want 2 1", wr_q.size(), loaded);
    end else begin
      checks++;
      if (wr_q[0].a != 0 || wr_q[1].a != 1 || wr_q[0].d != int'(16'h0007 ^ 16'hA5A5) || wr_q[1].d != int'(16'h0008 ^ 16'hA5A5)) begin
        errors++;
        $display("FAIL b2b_writes got %0d:%h %0d:%h want 0:a5a2 1:a5ad", wr_q[0].a, wr_q[0].d, wr_q[1].a, wr_q[1].d);
      end
    end
  endtask
  task automatic test_abort_busy;
    bit ok;
    int bad = 0;
    busy_len = 8;
    wr_q.delete();
    pulse_start(2);
    wait_wait_hi(ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pictsel = 3'd1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || active !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_early got active=%b busy=%b want 0 1", active, busy);
    end
    for (int i = 0; i < 50 && busy; i++) begin
      if (active) bad++;
      @(negedge clk);
    end
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (active) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (bad != 0 || !ok) begin
      errors++;
      $display("FAIL holdoff_release got early=%0d started=%0d want 0 1", bad, ok);
    end
    busy_len = 3;
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() != 4 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_load got writes=%0d loaded=%b want 4 1", wr_q.size(), loaded);
    end
  endtask
  task automatic test_async_reset;
    bit ok;
    busy_len = 6;
    pulse_start(1);
    wait_wait_hi(ok);
    #2 flashreset = 1'b1;
    #1;
    checks++;
    if (!ok || {writemode, doread, pix_we, active, loaded, sel_err} !== 6'b100000 || flashaddr !== '0 || pix_addr !== '0) begin
      errors++;
      $display("FAIL async_reset got flags=%b fa=%0d pa=%0d want 100000 0 0", {writemode, doread, pix_we, active, loaded, sel_err}, flashaddr, pix_addr);
    end
    @(negedge clk);
    flashreset = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    busy_len = 3;
  endtask
  task automatic test_random;
    bit ok;
    int sel;
    for (int k = 0; k < 10; k++) begin
      sel = $urandom_range(0, 7);
      busy_len = $urandom_range(1, 4);
      wr_q.delete();
      pulse_start(sel);
      wait_idle(ok);
      repeat (2) @(negedge clk);
      checks++;
      if (ref_len[sel] == 0) begin
        if (sel_err !== 1'b1 || loaded !== 1'b0 || wr_q.size() != 0) begin
          errors++;
          $display("FAIL rand%0d_invalid sel=%0d got err=%b loaded=%b writes=%0d want 1 0 0", k, sel, sel_err, loaded, wr_q.size());
        end
      end else if (!ok || sel_err !== 1'b0 || loaded !== 1'b1 || wr_q.size() != ref_len[sel] || flashaddr !== 23'(ref_base[sel] + ref_len[sel] - 1)) begin
        errors++;
        $display("FAIL rand%0d_load sel=%0d got writes=%0d fa=%0d loaded=%b want %0d %0d 1", k, sel, wr_q.size(), flashaddr, loaded, ref_len[sel], ref_base[sel] + ref_len[sel] - 1);
      end
      for (int i = 0; i < wr_q.size() && i < ref_len[sel]; i++) begin
        checks++;
        if (wr_q[i].a != i || wr_q[i].d != int'(16'(ref_base[sel] + i) ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %0d:%h want %0d:%h", k, i, wr_q[i].a, wr_q[i].d, i, 16'(ref_base[sel] + i) ^ 16'hA5A5);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_sel_err();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_abort_busy();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_image_loader.md
Name: flash_image_loader

Overview:
- Parametrised successor to the single-image flash read sequencer. Streams one image out of flash into the frame buffer using a table of per-image base addresses and lengths.
- Reads one flash word per busy handshake with the flash manager. Emits a pixel write strobe, a frame-buffer address and the data word for each read.
- Adds abort, invalid-selection error, progress status and re-triggering.
- Sits between the user/FSM top level, the flash manager and the ZBT writer.

Parameters:
- NUM_IMG, 8: number of table entries.
- SEL_W, 3: width of pictsel; 2**SEL_W must be >= NUM_IMG.
- ADDR_W, 23: flash word address width.
- CNT_W, 19: image length counter width; also the output address width.
- DATA_W, 16: flash data word width.
- IMG_BASE, packed NUM_IMG*ADDR_W: base flash address per entry. Entry i occupies bits [i*ADDR_W +: ADDR_W]. Defaults: 0→307201, 1→614401, 2→1152001, 3→1, 4→921601, 5–7→0.
- IMG_LEN, packed NUM_IMG*CNT_W: word count per entry. Defaults: 0–3→307200, 4→260400, 5–7→0.

Ports:
- clk in 1: system clock; all logic on rising edge.
- flashreset in 1: asynchronous, active-high reset.
- start in 1: request load; sampled only in IDLE or DONE.
- pictsel in SEL_W: image select; captured on accepted start.
- abort in 1: cancel the load in progress.
- busy in 1: flash manager busy.
- fdata in DATA_W: flash read data; valid in the cycle busy is seen falling.
- writemode out 1: flash manager mode; 0 = read.
- doread out 1: read request to the flash manager.
- flashaddr out ADDR_W: flash word address.
- pix_we out 1: one-cycle frame-buffer write strobe.
- pix_addr out CNT_W: frame-buffer address, 0-based per image.
- pix_data out DATA_W: word to write.
- active out 1: load in progress.
- loaded out 1: image complete; held until the next accepted start.
- sel_err out 1: last start selected an entry with length 0 or index >= NUM_IMG.

Behaviour:
- Reset (async): state IDLE. writemode=1, doread=0, flashaddr=0, pix_we=0, pix_addr=0, pix_data=0, active=0, loaded=0, sel_err=0. Internal remaining count = 0.
- States: IDLE, REQ, WAIT_HI, WAIT_LO, WRITE, DONE.
- IDLE/DONE + start:
  - Latch pictsel and clear loaded and sel_err.
  - If the entry is invalid: set sel_err=1, go to DONE with loaded=0.
  - Else: flashaddr ← IMG_BASE[sel], remaining ← IMG_LEN[sel], pix_addr ← 0, writemode ← 0, active ← 1, go to REQ.
- REQ: doread=1. Go to WAIT_HI when busy=1. doread stays asserted until busy is seen high.
- WAIT_HI: doread ← 0; wait for busy=0, then go to WAIT_LO. If busy is already low on entry, the next cycle samples.
- WAIT_LO: pix_data ← fdata, go to WRITE.
- WRITE:
  - pix_we=1 for exactly this cycle, with pix_addr and pix_data stable.
  - Next cycle: remaining ← remaining−1. If the new remaining is 0: loaded ← 1, active ← 0, go to DONE. Else flashaddr+1, pix_addr+1, go to REQ.
- Latency: at least 4 cycles per word plus flash busy time. The first pix_we is no earlier than 4 cycles after start.
- abort in REQ/WAIT_HI/WAIT_LO/WRITE:
  - Go to DONE next cycle with active=0, loaded=0, doread=0.
  - A pix_we already asserted that cycle completes; no further writes.
  - If in WAIT_HI with busy high, remain in DONE. The next start request is held off (treated as not sampled) until busy=0.
- abort and start in the same cycle in IDLE/DONE: start wins; abort is ignored.
- start while active: ignored. pictsel changes while active have no effect.
- flashaddr increments without wrap (base+len must fit ADDR_W; not checked). pix_addr never exceeds len−1.
- writemode stays 0 after the first load; it returns to 1 only on reset.

Test Plan:
- Set IMG_BASE[1]=100, IMG_LEN[1]=4; start with pictsel=1; the flash model gives busy 3 cycles and fdata=addr^16'hA5A5.
  - Required: exactly 4 pix_we pulses, pix_addr 0,1,2,3, data = {100..103}^A5A5.
  - Then loaded=1, active=0, flashaddr=103.
- pictsel=6 with IMG_LEN[6]=0: start → sel_err=1 next cycle, no doread, no pix_we, loaded=0. A following valid start clears sel_err.
- Length 4 load, abort asserted after the 2nd pix_we: no further pix_we, loaded stays 0, active=0. A restart with pictsel=1 rewrites pix_addr from 0.
- start pulsed again mid-load with pictsel=3: ignored. The load continues with entry 1 and flashaddr stays in 100..103.
- Assert flashreset asynchronously mid-WAIT_HI, with no clock edge: all outputs go to reset values immediately; writemode=1, doread=0.
- Back-to-back loads: start in DONE with pictsel=0 (len 2, base 7).
  - Required: loaded drops on the accepting edge, 2 writes at pix_addr 0,1, loaded rises again.
